// File: rtl/uart_sample_packer.sv
// Byte/word adapter between the board UART and the filter: LSB-first byte assembly (RX)
// and serialisation (TX). Define PACKER_CHECKSUM_EN to add a trailing XOR byte per word.
module uart_sample_packer #(
    parameter int WORD_BYTES  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_bvalid,
    output logic                    rx_bready,
    output logic [8*WORD_BYTES-1:0] smp_out,
    output logic                    smp_valid,
    input  logic                    smp_ready,
    input  logic [8*WORD_BYTES-1:0] smp_in,
    input  logic                    smp_in_valid,
    output logic                    smp_in_ready,
    output logic [7:0]              tx_byte,
    output logic                    tx_bvalid,
    input  logic                    tx_bready,
    output logic                    timeout_err,
    output logic                    frame_err
);
    localparam int W = 8*WORD_BYTES;
`ifdef PACKER_CHECKSUM_EN
    localparam int NB = WORD_BYTES + 1;
`else
    localparam int NB = WORD_BYTES;
`endif
    localparam int CW = $clog2(NB + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST  = CW'(NB - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    function automatic logic [7:0] xor_bytes(input logic [W-1:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < WORD_BYTES; i++) x ^= w[8*i +: 8];
        return x;
    endfunction

    function automatic logic [7:0] tx_sel(input logic [W-1:0] w, input logic [CW-1:0] i);
`ifdef PACKER_CHECKSUM_EN
        if (i == CW'(WORD_BYTES)) return xor_bytes(w);
`endif
        return w[8*i +: 8];
    endfunction

    // ---------------- RX path ----------------
    typedef enum logic {COLLECT, HOLD} rx_state_e;
    rx_state_e       rx_st_q, rx_st_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic [W-1:0]    acc_q, acc_d, smp_q, smp_d;
    logic            rx_bready_q, rx_bready_d, smp_valid_q, smp_valid_d;
    logic            tmo_q, tmo_d, ferr_q, ferr_d;
    logic            rx_acc;

    assign rx_acc = rx_bvalid & rx_bready_q;

    always_comb begin
        rx_st_d     = rx_st_q;
        rx_cnt_d    = rx_cnt_q;
        idle_d      = idle_q;
        acc_d       = acc_q;
        smp_d       = smp_q;
        rx_bready_d = rx_bready_q;
        smp_valid_d = smp_valid_q;
        tmo_d       = 1'b0;
        ferr_d      = 1'b0;
        case (rx_st_q)
            COLLECT: begin
                rx_bready_d = 1'b1;
                if (rx_acc) begin
                    idle_d = '0;
                    if (rx_cnt_q == LAST) begin
                        rx_cnt_d = '0;
`ifdef PACKER_CHECKSUM_EN
                        if (rx_byte == xor_bytes(acc_q)) begin
                            smp_d       = acc_q;
                            smp_valid_d = 1'b1;
                            rx_bready_d = 1'b0;
                            rx_st_d     = HOLD;
                        end else begin
                            ferr_d = 1'b1;
                        end
`else
                        smp_d                        = acc_q;
                        smp_d[8*(WORD_BYTES-1) +: 8] = rx_byte;
                        smp_valid_d                  = 1'b1;
                        rx_bready_d                  = 1'b0;
                        rx_st_d                      = HOLD;
`endif
                    end else begin
                        acc_d[8*rx_cnt_q +: 8] = rx_byte;
                        rx_cnt_d               = rx_cnt_q + 1'b1;
                    end
                end else if (rx_cnt_q != '0) begin
                    // an accepted byte in the expiry cycle takes the branch above instead
                    if (idle_q == TLAST) begin
                        rx_cnt_d = '0;
                        idle_d   = '0;
                        tmo_d    = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (smp_ready && smp_valid_q) begin
                    rx_st_d     = COLLECT;
                    smp_valid_d = 1'b0;
                    rx_bready_d = 1'b1;
                end
            end
            default: rx_st_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st_q     <= COLLECT;
            rx_cnt_q    <= '0;
            idle_q      <= '0;
            acc_q       <= '0;
            smp_q       <= '0;
            rx_bready_q <= 1'b0;
            smp_valid_q <= 1'b0;
            tmo_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            rx_st_q     <= rx_st_d;
            rx_cnt_q    <= rx_cnt_d;
            idle_q      <= idle_d;
            acc_q       <= acc_d;
            smp_q       <= smp_d;
            rx_bready_q <= rx_bready_d;
            smp_valid_q <= smp_valid_d;
            tmo_q       <= tmo_d;
            ferr_q      <= ferr_d;
        end
    end

    // ---------------- TX path ----------------
    typedef enum logic {IDLE, SEND} tx_state_e;
    tx_state_e       tx_st_q, tx_st_d;
    logic [W-1:0]    tx_word_q, tx_word_d;
    logic [CW-1:0]   tx_idx_q, tx_idx_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_bvalid_q, tx_bvalid_d, sin_rdy_q, sin_rdy_d;

    always_comb begin
        tx_st_d     = tx_st_q;
        tx_word_d   = tx_word_q;
        tx_idx_d    = tx_idx_q;
        tx_byte_d   = tx_byte_q;
        tx_bvalid_d = tx_bvalid_q;
        sin_rdy_d   = sin_rdy_q;
        case (tx_st_q)
            IDLE: begin
                sin_rdy_d = 1'b1;
                if (smp_in_valid && sin_rdy_q) begin
                    tx_word_d   = smp_in;
                    tx_idx_d    = '0;
                    tx_byte_d   = smp_in[7:0];
                    tx_bvalid_d = 1'b1;
                    sin_rdy_d   = 1'b0;
                    tx_st_d     = SEND;
                end
            end
            SEND: begin
                if (tx_bready && tx_bvalid_q) begin
                    if (tx_idx_q == LAST) begin
                        tx_bvalid_d = 1'b0;
                        sin_rdy_d   = 1'b1;
                        tx_st_d     = IDLE;
                    end else begin
                        tx_idx_d  = tx_idx_q + 1'b1;
                        tx_byte_d = tx_sel(tx_word_q, tx_idx_q + 1'b1);
                    end
                end
            end
            default: tx_st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st_q     <= IDLE;
            tx_word_q   <= '0;
            tx_idx_q    <= '0;
            tx_byte_q   <= '0;
            tx_bvalid_q <= 1'b0;
            sin_rdy_q   <= 1'b0;
        end else begin
            tx_st_q     <= tx_st_d;
            tx_word_q   <= tx_word_d;
            tx_idx_q    <= tx_idx_d;
            tx_byte_q   <= tx_byte_d;
            tx_bvalid_q <= tx_bvalid_d;
            sin_rdy_q   <= sin_rdy_d;
        end
    end

    assign rx_bready    = rx_bready_q;
    assign smp_out      = smp_q;
    assign smp_valid    = smp_valid_q;
    assign smp_in_ready = sin_rdy_q;
    assign tx_byte      = tx_byte_q;
    assign tx_bvalid    = tx_bvalid_q;
    assign timeout_err  = tmo_q;
    assign frame_err    = ferr_q;
endmodule

// File: doc/uart_sample_packer.md
Name: uart_sample_packer

Overview:
- Byte/word adapter between the board UART and the filter datapath.
- RX path: assembles UART bytes, LSB first, into WORD_BYTES-wide samples and feeds them to the filter input (sin).
- TX path: serialises filter output samples (sout) back into UART bytes, LSB first.
- The two paths are independent and full-duplex; all handshakes are valid/ready.

Parameters:
- WORD_BYTES, 4, bytes per sample; sample width is 8*WORD_BYTES.
- TIMEOUT_CYC, 50000, idle clk cycles after which a partial RX word is discarded; must be ≥2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- rx_byte  in  8  byte from UART receiver.
- rx_bvalid  in  1  rx_byte valid.
- rx_bready  out  1  packer accepts rx_byte.
- smp_out  out  32  assembled sample to filter.
- smp_valid  out  1  smp_out valid.
- smp_ready  in  1  filter accepts smp_out.
- smp_in  in  32  filter output sample.
- smp_in_valid  in  1  smp_in valid.
- smp_in_ready  out  1  packer accepts smp_in.
- tx_byte  out  8  byte to UART transmitter.
- tx_bvalid  out  1  tx_byte valid.
- tx_bready  in  1  UART transmitter accepts tx_byte.
- timeout_err  out  1  one-cycle pulse when a partial RX word is dropped on timeout.
- frame_err  out  1  one-cycle pulse when an RX word fails the checksum; tied 0 when the checksum feature is out.

Behaviour:
- All outputs are registered. Transfers occur on a rising clk edge with valid & ready both high.
- Reset values: every output is 0.
  - rx_bready and smp_in_ready rise on the first clk edge after rst deasserts.
  - rst mid-operation discards partial RX words and any TX word in progress; no output is produced for them.
- RX FSM, states COLLECT and HOLD:
  - COLLECT: rx_bready=1. Accepted byte k (k=0..WORD_BYTES-1) is written to bits [8k+7:8k]. The byte counter increments per accepted byte.
  - On the last byte the FSM enters HOLD on the next edge, with smp_valid=1 and rx_bready=0. Latency from last-byte edge to smp_valid is 1 cycle.
  - HOLD: smp_out stays stable until smp_ready. On handshake: next state COLLECT, counter=0, smp_valid=0, rx_bready=1.
  - No back-to-back overlap: a byte is never accepted in the same cycle a word is handed off.
- Timeout (RX):
  - The idle counter runs only in COLLECT with counter>0. It clears on each accepted byte.
  - At TIMEOUT_CYC-1: partial word dropped, counter=0, timeout_err pulses for 1 cycle.
  - If a byte is accepted in the expiry cycle, the byte wins: no error, timer cleared.
- TX FSM, states IDLE and SEND:
  - IDLE: smp_in_ready=1. On handshake, latch smp_in and enter SEND with idx=0; tx_bvalid rises on the next cycle.
  - SEND: smp_in_ready=0, tx_bvalid=1, tx_byte=word[8idx+7:8idx]. tx_byte is held until tx_bready.
  - idx advances per accepted byte. After the last byte the FSM returns to IDLE, with smp_in_ready=1 the following cycle.
- RX and TX never block each other; simultaneous activity on both paths is legal.

Optional Feature:
- Macro: PACKER_CHECKSUM_EN.
- With the macro: each word is followed on the wire by one extra byte equal to the XOR of its WORD_BYTES data bytes.
  - RX collects WORD_BYTES+1 bytes. On match it enters HOLD as normal.
  - On mismatch: word dropped, no smp_valid, frame_err pulses 1 cycle, return to COLLECT with counter=0.
  - TX appends the XOR byte after the data bytes.
- Without the macro: no checksum byte in either direction, frame_err=0 constantly.

Test Plan:
1. RX bytes 78,56,34,12 back-to-back, smp_ready=0 for 5 cycles -> smp_out=0x12345678 with smp_valid 1 cycle after 4th byte; value stable and rx_bready=0 throughout; after smp_ready, smp_valid=0 and rx_bready=1.
2. smp_in=0xDEADBEEF, tx_bready toggling 1/0 -> tx_byte sequence EF,BE,AD,DE, each held while tx_bready=0; smp_in_ready=0 until last byte accepted.
3. TIMEOUT_CYC=16: bytes AA,BB then idle 16 cycles -> timeout_err single pulse, no smp_valid; then 01,02,03,04 -> smp_out=0x04030201.
4. Assert rst after 3 RX bytes and during TX byte 2 -> all outputs 0, no smp_valid, tx_bvalid=0; post-reset bytes 11,22,33,44 -> 0x44332211.
5. PACKER_CHECKSUM_EN: RX 78,56,34,12,08 -> smp_out=0x12345678; RX 78,56,34,12,09 -> frame_err pulse, no smp_valid; TX 0x12345678 -> 78,56,34,12,08.
6. RX word and TX word concurrently with random ready stalls -> both complete correctly, no cross-blocking, no error pulses.
